// File: rtl/branch_target_table.sv
// Programmable branch target table with registered lookup.
// Entries are absolute or PC-relative; reset loads legacy defaults.
module branch_target_table #(
    parameter int D     = 12,
    parameter int AW    = 4,
    parameter int DEPTH = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Req,
    input  logic [AW-1:0] Addr,
    input  logic [D-1:0]  PC,
    input  logic          WrEn,
    input  logic [AW-1:0] WrAddr,
    input  logic [D-1:0]  WrData,
    input  logic          WrRel,
    output logic          Ack,
    output logic [D-1:0]  Target,
    output logic          Miss
);

    logic [D-1:0] val_q [DEPTH];
    logic [D-1:0] val_d [DEPTH];
    logic         rel_q [DEPTH];
    logic         rel_d [DEPTH];
    logic         vld_q [DEPTH];
    logic         vld_d [DEPTH];

    logic         ack_q;
    logic         ack_d;
    logic         miss_q;
    logic         miss_d;
    logic [D-1:0] target_q;
    logic [D-1:0] target_d;

    logic         rd_hit;
    logic         rd_rel;
    logic [D-1:0] rd_val;

    // Legacy jump targets 13, 25, 37, 49 for entries 0..3.
    function automatic logic [D-1:0] reset_val(input int idx);
        if (idx < 4) begin
            return D'(13 + 12 * idx);
        end
        return '0;
    endfunction

    // Next state of the entry storage: in-range writes only.
    always_comb begin
        val_d = val_q;
        rel_d = rel_q;
        vld_d = vld_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (WrEn && (WrAddr == AW'(i))) begin
                val_d[i] = WrData;
                rel_d[i] = WrRel;
                vld_d[i] = 1'b1;
            end
        end
    end

    // Read selection with write-first forwarding on a same-index write.
    always_comb begin
        rd_hit = 1'b0;
        rd_rel = 1'b0;
        rd_val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (Addr == AW'(i)) begin
                if (WrEn && (WrAddr == Addr)) begin
                    rd_hit = 1'b1;
                    rd_rel = WrRel;
                    rd_val = WrData;
                end else begin
                    rd_hit = vld_q[i];
                    rd_rel = rel_q[i];
                    rd_val = val_q[i];
                end
            end
        end
    end

    // Resolve the lookup result; Target holds when no request.
    always_comb begin
        ack_d    = Req;
        miss_d   = Req && !rd_hit;
        target_d = target_q;
        if (Req) begin
            if (!rd_hit) begin
                target_d = '0;
            end else if (rd_rel) begin
                target_d = PC + rd_val;
            end else begin
                target_d = rd_val;
            end
        end
    end

    // Storage registers, reloaded with defaults on reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                val_q[i] <= reset_val(i);
                rel_q[i] <= 1'b0;
                vld_q[i] <= (i < 4);
            end
        end else begin
            val_q <= val_d;
            rel_q <= rel_d;
            vld_q <= vld_d;
        end
    end

    // Output registers; reset drops any in-flight lookup.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ack_q    <= 1'b0;
            miss_q   <= 1'b0;
            target_q <= '0;
        end else begin
            ack_q    <= ack_d;
            miss_q   <= miss_d;
            target_q <= target_d;
        end
    end

    assign Ack    = ack_q;
    assign Miss   = miss_q;
    assign Target = target_q;

endmodule

// File: tb/tb_branch_target_table.sv
// Directed bench for branch_target_table.
// Runs a 16-entry and an 8-entry table side by side.
module tb_branch_target_table;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Req;
    logic [3:0]  Addr;
    logic [11:0] PC;
    logic        WrEn;
    logic [3:0]  WrAddr;
    logic [11:0] WrData;
    logic        WrRel;
    logic        Ack;
    logic [11:0] Target;
    logic        Miss;
    logic        Ack8;
    logic [11:0] Target8;
    logic        Miss8;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    branch_target_table #(.D(12), .AW(4), .DEPTH(16)) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Addr(Addr), .PC(PC),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .WrRel(WrRel),
        .Ack(Ack), .Target(Target), .Miss(Miss)
    );

    branch_target_table #(.D(12), .AW(4), .DEPTH(8)) dut8 (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Addr(Addr), .PC(PC),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .WrRel(WrRel),
        .Ack(Ack8), .Target(Target8), .Miss(Miss8)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic out3(input string tag, input logic a,
                        input logic [11:0] t, input logic m);
        chk({tag, "_ack"}, {31'd0, Ack}, {31'd0, a});
        chk({tag, "_tgt"}, {20'd0, Target}, {20'd0, t});
        chk({tag, "_miss"}, {31'd0, Miss}, {31'd0, m});
    endtask

    task automatic wr(input logic [3:0] a, input logic [11:0] d,
                      input logic r);
        WrEn   = 1'b1;
        WrAddr = a;
        WrData = d;
        WrRel  = r;
        Req    = 1'b0;
        tick();
        WrEn   = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [11:0] pc);
        Req  = 1'b1;
        Addr = a;
        PC   = pc;
        tick();
    endtask

    initial begin
        Reset  = 1'b1;
        Req    = 1'b0;
        Addr   = '0;
        PC     = '0;
        WrEn   = 1'b0;
        WrAddr = '0;
        WrData = '0;
        WrRel  = 1'b0;
        tick();
        tick();
        out3("reset", 1'b0, 12'd0, 1'b0);

        // legacy defaults, back-to-back
        Reset = 1'b0;
        rd(4'd0, 12'd0);
        out3("def0", 1'b1, 12'd13, 1'b0);
        rd(4'd1, 12'd0);
        out3("def1", 1'b1, 12'd25, 1'b0);
        rd(4'd2, 12'd0);
        out3("def2", 1'b1, 12'd37, 1'b0);
        rd(4'd3, 12'd0);
        out3("def3", 1'b1, 12'd49, 1'b0);
        chk("def3_d8", {20'd0, Target8}, 32'd49);
        Req = 1'b0;
        tick();
        out3("idle_hold", 1'b0, 12'd49, 1'b0);

        // entry 4 unprogrammed after reset
        rd(4'd4, 12'd0);
        out3("unprog4", 1'b1, 12'd0, 1'b1);

        // relative wrap-around
        wr(4'd5, 12'hFFF, 1'b1);
        rd(4'd5, 12'd4);
        out3("rel_pc4", 1'b1, 12'd3, 1'b0);
        rd(4'd5, 12'd0);
        out3("rel_pc0", 1'b1, 12'hFFF, 1'b0);
        rd(4'd5, 12'd4);
        Req = 1'b0;
        PC  = 12'd100;
        tick();
        out3("pc_sampled", 1'b0, 12'd3, 1'b0);

        wr(4'd6, 12'd20, 1'b1);
        rd(4'd6, 12'hFF0);
        out3("rel_wrap", 1'b1, 12'h004, 1'b0);

        // index 9: never written, then beyond DEPTH for dut8
        rd(4'd9, 12'd0);
        out3("miss9", 1'b1, 12'd0, 1'b1);
        chk("miss9_d8", {31'd0, Miss8}, 32'd1);
        wr(4'd9, 12'd77, 1'b0);
        rd(4'd9, 12'd0);
        out3("hit9", 1'b1, 12'd77, 1'b0);
        chk("oor9_d8_miss", {31'd0, Miss8}, 32'd1);
        chk("oor9_d8_tgt", {20'd0, Target8}, 32'd0);
        chk("oor9_d8_ack", {31'd0, Ack8}, 32'd1);

        // same-edge write and lookup: write-first
        WrEn   = 1'b1;
        WrAddr = 4'd2;
        WrData = 12'd100;
        WrRel  = 1'b0;
        rd(4'd2, 12'd0);
        out3("wfirst", 1'b1, 12'd100, 1'b0);
        WrEn = 1'b0;
        rd(4'd2, 12'd0);
        out3("wfirst_after", 1'b1, 12'd100, 1'b0);

        // forward relative entry on same edge
        WrEn   = 1'b1;
        WrAddr = 4'd7;
        WrData = 12'd10;
        WrRel  = 1'b1;
        rd(4'd7, 12'd5);
        out3("wfirst_rel", 1'b1, 12'd15, 1'b0);
        WrEn = 1'b0;

        // reset restores defaults
        wr(4'd0, 12'd500, 1'b0);
        rd(4'd0, 12'd0);
        out3("wr0", 1'b1, 12'd500, 1'b0);
        Req   = 1'b0;
        Reset = 1'b1;
        tick();
        out3("rst_again", 1'b0, 12'd0, 1'b0);
        Reset = 1'b0;
        rd(4'd0, 12'd0);
        out3("rst_def0", 1'b1, 12'd13, 1'b0);
        rd(4'd5, 12'd4);
        out3("rst_clr5", 1'b1, 12'd0, 1'b1);

        // Req ignored in a reset cycle
        Reset = 1'b1;
        rd(4'd1, 12'd0);
        out3("rst_req", 1'b0, 12'd0, 1'b0);

        // reset the cycle after a Req drops it
        Reset = 1'b0;
        rd(4'd1, 12'd0);
        out3("pre_drop", 1'b1, 12'd25, 1'b0);
        Req   = 1'b0;
        Reset = 1'b1;
        tick();
        out3("drop", 1'b0, 12'd0, 1'b0);
        Reset = 1'b0;
        tick();
        out3("drop_idle", 1'b0, 12'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
